// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync and display-enable strobes
// with a configurable output pipeline, plus frame and vblank event pulses.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] Y_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [15:0] r_frame_count;
  logic        r_frame_start;
  logic        r_vblank_start;

  logic w_x_last;
  logic w_y_last;
  logic w_frame_wrap;
  logic w_vblank_hit;
  logic w_hsync_raw;
  logic w_vsync_raw;
  logic w_active_raw;

  assign w_x_last     = (r_x == X_LAST);
  assign w_y_last     = (r_y == Y_LAST);
  assign w_frame_wrap = w_x_last & w_y_last;
  assign w_vblank_hit = w_x_last & (r_y == Y_VIS_LAST);

  // Pulses are recomputed on every edge so they drop after one clk even while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x            <= '0;
      r_y            <= '0;
      r_frame_count  <= '0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_frame_start  <= enable & w_frame_wrap;
      r_vblank_start <= enable & w_vblank_hit;
      if (enable) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
        if (w_frame_wrap) begin
          r_frame_count <= r_frame_count + 16'd1;
        end
      end
    end
  end

  assign w_hsync_raw  = ~((r_x >= HS_FIRST) && (r_x <= HS_LAST));
  assign w_vsync_raw  = ~((r_y >= VS_FIRST) && (r_y <= VS_LAST));
  assign w_active_raw = (r_x < X_VIS) && (r_y < Y_VIS);

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hsync  = w_hsync_raw;
    assign vsync  = w_vsync_raw;
    assign active = w_active_raw;
  end else begin : g_delay
    // Each stage holds {hsync, vsync, active}; idle value keeps syncs deasserted.
    logic [2:0] r_pipe [SYNC_DELAY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          r_pipe[i] <= 3'b110;
        end
      end else if (enable) begin
        r_pipe[0] <= {w_hsync_raw, w_vsync_raw, w_active_raw};
        for (int i = 1; i < SYNC_DELAY; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign {hsync, vsync, active} = r_pipe[SYNC_DELAY-1];
  end

  assign x            = r_x;
  assign y            = r_y;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x10 raster (frame = 160 enabled cycles),
// with a delayed (SYNC_DELAY=2) and an undelayed (SYNC_DELAY=0) instance sharing stimulus.
module tb_vga_timing_gen;

  // Raster: H 8+2+3+3=16 (hsync low x=10..12), V 6+1+2+1=10 (vsync low y=7..8).
  localparam int unsigned HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VV = 6, VF = 1, VS = 2, VB = 1;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  logic [9:0]  a_x, a_y, b_x, b_y;
  logic        a_hsync, a_vsync, a_active, a_fs, a_vb;
  logic        b_hsync, b_vsync, b_active, b_fs, b_vb;
  logic [15:0] a_fc, b_fc;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_DELAY(2)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .x(a_x), .y(a_y),
    .hsync(a_hsync), .vsync(a_vsync), .active(a_active),
    .frame_start(a_fs), .vblank_start(a_vb), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_DELAY(0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .x(b_x), .y(b_y),
    .hsync(b_hsync), .vsync(b_vsync), .active(b_active),
    .frame_start(b_fs), .vblank_start(b_vb), .frame_count(b_fc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hs_lo, vs_lo, act_hi, fs_hi, vb_hi, b_act_hi;
  int first_hs, first_act, first_fs, first_vb, first_b_hs;
  int e;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    check_eq("rst_x", 32'(a_x), 0);
    check_eq("rst_y", 32'(a_y), 0);
    check_eq("rst_hsync", 32'(a_hsync), 1);
    check_eq("rst_vsync", 32'(a_vsync), 1);
    check_eq("rst_active", 32'(a_active), 0);
    check_eq("rst_frame_start", 32'(a_fs), 0);
    check_eq("rst_vblank_start", 32'(a_vb), 0);
    check_eq("rst_frame_count", 32'(a_fc), 0);

    // Three free-running frames.
    reset = 1'b0;
    #1;
    check_eq("nodelay_active_at_origin", 32'(b_active), 1);
    check_eq("delay_active_at_origin", 32'(a_active), 0);

    hs_lo = 0; vs_lo = 0; act_hi = 0; fs_hi = 0; vb_hi = 0; b_act_hi = 0;
    first_hs = -1; first_act = -1; first_fs = -1; first_vb = -1; first_b_hs = -1;
    for (int k = 1; k <= 480; k++) begin
      tick();
      check_eq("run_x", 32'(a_x), 32'(k % 16));
      check_eq("run_y", 32'(a_y), 32'((k / 16) % 10));
      if (!a_hsync) begin hs_lo++; if (first_hs < 0) first_hs = k; end
      if (!a_vsync) vs_lo++;
      if (a_active) begin act_hi++; if (first_act < 0) first_act = k; end
      if (a_fs) begin fs_hi++; if (first_fs < 0) first_fs = k; end
      if (a_vb) begin vb_hi++; if (first_vb < 0) first_vb = k; end
      if (!b_hsync && first_b_hs < 0) first_b_hs = k;
      if (b_active) b_act_hi++;
      if (k == 160) check_eq("frame_count_after_1", 32'(a_fc), 1);
    end
    check_eq("first_active", first_act, 2);
    check_eq("first_hsync_low", first_hs, 12);
    check_eq("first_hsync_low_nodelay", first_b_hs, 10);
    check_eq("first_frame_start", first_fs, 160);
    check_eq("first_vblank_start", first_vb, 96);
    check_eq("hsync_low_cycles_3f", hs_lo, 90);
    check_eq("vsync_low_cycles_3f", vs_lo, 96);
    check_eq("active_cycles_3f", act_hi, 144);
    check_eq("active_cycles_3f_nodelay", b_act_hi, 144);
    check_eq("frame_start_cycles_3f", fs_hi, 3);
    check_eq("vblank_start_cycles_3f", vb_hi, 3);
    check_eq("frame_count_3f", 32'(a_fc), 3);

    // Enable toggling 1/0: one frame of enabled edges over 320 clk cycles.
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    hs_lo = 0; vs_lo = 0; act_hi = 0; fs_hi = 0;
    first_hs = -1; first_act = -1; first_fs = -1;
    for (int k = 1; k <= 320; k++) begin
      tick();
      e = (k + 1) / 2;
      check_eq("stall_x", 32'(a_x), 32'(e % 16));
      check_eq("stall_y", 32'(a_y), 32'((e / 16) % 10));
      if (!a_hsync) begin hs_lo++; if (first_hs < 0) first_hs = k; end
      if (!a_vsync) vs_lo++;
      if (a_active) begin act_hi++; if (first_act < 0) first_act = k; end
      if (a_fs) begin fs_hi++; if (first_fs < 0) first_fs = k; end
      enable = (k % 2 == 0);
    end
    check_eq("stall_first_active", first_act, 3);
    check_eq("stall_first_hsync_low", first_hs, 23);
    check_eq("stall_first_frame_start", first_fs, 319);
    check_eq("stall_frame_start_cycles", fs_hi, 1);
    check_eq("stall_hsync_low_cycles", hs_lo, 60);
    check_eq("stall_vsync_low_cycles", vs_lo, 64);
    check_eq("stall_active_cycles", act_hi, 96);
    check_eq("stall_frame_count", 32'(a_fc), 1);

    // Mid-frame asynchronous reset while the delayed hsync is low.
    enable = 1'b1;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    repeat (60) tick();
    check_eq("pre_reset_x", 32'(a_x), 12);
    check_eq("pre_reset_y", 32'(a_y), 3);
    check_eq("pre_reset_hsync", 32'(a_hsync), 0);
    check_eq("pre_reset_active", 32'(a_active), 0);
    reset = 1'b1;
    #1;
    check_eq("async_reset_x", 32'(a_x), 0);
    check_eq("async_reset_y", 32'(a_y), 0);
    check_eq("async_reset_hsync", 32'(a_hsync), 1);
    check_eq("async_reset_active", 32'(a_active), 0);
    check_eq("async_reset_frame_start", 32'(a_fs), 0);
    repeat (2) tick();
    reset = 1'b0;
    fs_hi = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (a_fs) fs_hi++;
    end
    check_eq("post_reset_no_frame_start", fs_hi, 0);
    check_eq("post_reset_x", 32'(a_x), 10);
    check_eq("post_reset_frame_count", 32'(a_fc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
